// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-cycle tick every div clk cycles (div=0 acts as 1).
// Combinational tick, no backpressure; restart zeroes the count and suppresses that cycle's tick.
module uart_baud_tick #(
  parameter int DIVWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIVWIDTH-1:0] div,
  input  logic                restart,
  output logic                tick
);

  logic [DIVWIDTH-1:0] cnt;
  logic [DIVWIDTH-1:0] last;

  // >= rather than == so a div decrease mid-count cannot strand the counter
  assign last = (div == '0) ? '0 : div - 1'b1;
  assign tick = !restart && (cnt >= last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || (cnt >= last)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start, DATAWIDTH bits LSB first, optional parity, one stop bit.
// rx_done pulses 1 clk after the stop-bit decision tick (+2 clk synchronizer); no backpressure.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int DIVWIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIVWIDTH-1:0]  div,
  input  logic                 parityEnable,
  input  logic                 parityType,
  input  logic                 rx,
  output logic [DATAWIDTH-1:0] rx_out,
  output logic                 rx_done,
  output logic                 parityError,
  output logic                 parityErrorValid,
  output logic                 framingError
);

  localparam int SW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATAWIDTH) + 1;
  localparam logic [SW-1:0] M_LO   = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] M_MID  = SW'(OVERSAMPLING / 2);
  localparam logic [SW-1:0] M_HI   = SW'(OVERSAMPLING / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATAWIDTH - 1);

  rx_state_t            state, state_nxt;
  logic                 rx_m, rx_s, rx_d;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 smp0, smp1;
  logic [DATAWIDTH-1:0] shreg;
  logic                 pen_l, ptype_l, par_err;
  logic                 tick, start_edge, decide, bit_end, bit_val;

  assign start_edge = (state == IDLE) && rx_d && !rx_s;
  assign decide     = tick && (samp_cnt == M_HI);
  assign bit_end    = tick && (samp_cnt == S_LAST);
  assign bit_val    = majority3(smp0, smp1, rx_s);

  uart_baud_tick #(.DIVWIDTH(DIVWIDTH)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .div     (div),
    .restart (start_edge),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (decide && bit_val) state_nxt = IDLE;
               else if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && (bit_cnt == B_LAST)) state_nxt = pen_l ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (decide) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m             <= 1'b1;
      rx_s             <= 1'b1;
      rx_d             <= 1'b1;
      samp_cnt         <= '0;
      bit_cnt          <= '0;
      smp0             <= 1'b0;
      smp1             <= 1'b0;
      shreg            <= '0;
      pen_l            <= 1'b0;
      ptype_l          <= 1'b0;
      par_err          <= 1'b0;
      rx_out           <= '0;
      rx_done          <= 1'b0;
      parityError      <= 1'b0;
      parityErrorValid <= 1'b0;
      framingError     <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_d    <= rx_s;
      rx_done <= 1'b0;

      if (state == IDLE) begin
        samp_cnt <= '0;
      end else if (tick) begin
        samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + 1'b1;
      end

      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (bit_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (tick && (samp_cnt == M_LO))  smp0 <= rx_s;
      if (tick && (samp_cnt == M_MID)) smp1 <= rx_s;

      if (start_edge) begin
        pen_l   <= parityEnable;
        ptype_l <= parityType;
        par_err <= 1'b0;
      end

      if ((state == DATA) && decide) begin
        shreg <= {bit_val, shreg[DATAWIDTH-1:1]};
      end

      if ((state == PARITY) && decide) begin
        par_err <= (^shreg) ^ ptype_l ^ bit_val;
      end

      // Completion is taken mid-stop-bit so a following start edge is never missed
      if ((state == STOP) && decide) begin
        rx_out           <= shreg;
        framingError     <= ~bit_val;
        parityError      <= pen_l & par_err;
        parityErrorValid <= pen_l;
        rx_done          <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected results, a monitor checks each rx_done.
module tb_uart_rx_core;

  localparam int BITCLK = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] div = 16'd10;
  logic        parityEnable = 1'b0;
  logic        parityType = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  rx_out;
  logic        rx_done;
  logic        parityError;
  logic        parityErrorValid;
  logic        framingError;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       pval;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  uart_rx_core #(.DATAWIDTH(8), .OVERSAMPLING(16), .DIVWIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .div              (div),
    .parityEnable     (parityEnable),
    .parityType       (parityType),
    .rx               (rx),
    .rx_out           (rx_out),
    .rx_done          (rx_done),
    .parityError      (parityError),
    .parityErrorValid (parityErrorValid),
    .framingError     (framingError)
  );

  always #625 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BITCLK) @(negedge clk);
  endtask

  // pbit is the literal parity bit put on the line; expected results come in separately
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                            input logic pbit, input logic stop_v, input int gap,
                            input logic [7:0] e_data, input logic e_perr,
                            input logic e_pval, input logic e_ferr);
    exp_t e;
    e.data = e_data; e.perr = e_perr; e.pval = e_pval; e.ferr = e_ferr;
    exp_q.push_back(e);
    parityEnable = pen;
    parityType   = ptype;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    if (pen) hold_bit(pbit);
    hold_bit(stop_v);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rx_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rx_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_out", 32'(rx_out), 32'(e.data));
        check("parityError", 32'(parityError), 32'(e.perr));
        check("parityErrorValid", 32'(parityErrorValid), 32'(e.pval));
        check("framingError", 32'(framingError), 32'(e.ferr));
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_rx_out", 32'(rx_out), 32'h0);
    check("reset_rx_done", 32'(rx_done), 32'h0);
    check("reset_parityError", 32'(parityError), 32'h0);
    check("reset_parityErrorValid", 32'(parityErrorValid), 32'h0);
    check("reset_framingError", 32'(framingError), 32'h0);
    rst = 1'b1;
    repeat (200) @(negedge clk);

    // 0xDB has six ones: even parity bit 0 is correct
    send_frame(8'hDB, 1'b1, 1'b0, 1'b0, 1'b1, 320, 8'hDB, 1'b0, 1'b1, 1'b0);
    // 0xF1 has five ones: even parity needs 1, 0 is wrong
    send_frame(8'hF1, 1'b1, 1'b0, 1'b0, 1'b1, 320, 8'hF1, 1'b1, 1'b1, 1'b0);
    // parity off, stop bit low
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 320, 8'h81, 1'b0, 1'b0, 1'b1);

    // 30-clk glitch is a false start; outputs keep the 0x81 frame
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_rx_out", 32'(rx_out), 32'h81);
    check("glitch_framingError", 32'(framingError), 32'h1);
    check("glitch_parityErrorValid", 32'(parityErrorValid), 32'h0);

    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 320, 8'hAA, 1'b0, 1'b0, 1'b0);

    // abort 0xA5 halfway through data bit 4 with reset
    parityEnable = 1'b0;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'((8'hA5 >> i) & 8'h01));
    rx = 1'b0;
    repeat (BITCLK / 2) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (BITCLK * 12) @(negedge clk);
    check("abort_rx_out", 32'(rx_out), 32'h0);
    check("abort_framingError", 32'(framingError), 32'h0);
    check("abort_parityErrorValid", 32'(parityErrorValid), 32'h0);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 400, 8'h3C, 1'b0, 1'b0, 1'b0);

    check("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
